// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
//
// Converts the five EGo1 push buttons into time-setting commands for the
// HH-MM-SS timekeeper. Each button is synchronised, debounced and reduced to a
// single-cycle press event. An edit FSM then walks a shadow copy of the time.
//
// Edit flow:
//   - Center in IDLE captures the live time and starts editing the hour field.
//   - Up/down change the selected field and wrap at its limits.
//   - Left/right move the selection between fields.
//   - Center while editing commits the shadow time with a one-cycle load.
//   - An inactivity timeout abandons the edit without a load.
//
// Ports:
//   clk       system clock (100 MHz)
//   rst       synchronous reset, active-low
//   key[4:0]  raw buttons, active-high, asynchronous
//             [0]=center [1]=up [2]=down [3]=left [4]=right
//   cur_hour  live hour from the timekeeper (0-23)
//   cur_min   live minute (0-59)
//   cur_sec   live second (0-59)
//   set_hour  shadow hour
//   set_min   shadow minute
//   set_sec   shadow second
//   load      one-cycle strobe; the timekeeper copies set_* while high
//   editing   high in any edit state
//   field     field being edited: 0=none, 1=hour, 2=min, 3=sec
// ---------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int DEBOUNCE_CYC = 2000000,
    parameter int TIMEOUT_CYC  = 1000000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] key,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       load,
    output logic       editing,
    output logic [1:0] field
);

    // The debounce counter never exceeds DEBOUNCE_CYC-1.
    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT_H = 2'd1,
        EDIT_M = 2'd2,
        EDIT_S = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser, debounce and press detection
    // ------------------------------------------------------------------
    logic [4:0] s1_reg;
    logic [4:0] s2_reg;
    logic [4:0] db_vec;
    logic [4:0] db_d_reg;
    logic [4:0] evt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            db_d_reg <= '0;
        end else begin
            s1_reg   <= key;
            s2_reg   <= s1_reg;
            db_d_reg <= db_vec;
        end
    end

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_debounce
            logic [DB_W-1:0] cnt_reg;
            logic            db_reg;

            // The debounced level flips only after DEBOUNCE_CYC consecutive
            // cycles of disagreement; any agreement restarts the count.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_reg <= '0;
                    db_reg  <= 1'b0;
                end else if (s2_reg[gi] != db_reg) begin
                    if (cnt_reg == DB_W'(DEBOUNCE_CYC - 1)) begin
                        db_reg  <= s2_reg[gi];
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end

            assign db_vec[gi] = db_reg;
        end
    endgenerate

    // Rising edge of the debounced level only: no repeat, no release events.
    assign evt = db_vec & ~db_d_reg;

    // ------------------------------------------------------------------
    // Field arithmetic
    // ------------------------------------------------------------------
    // Out-of-range captured values fall into the wrap branch on either step.
    function automatic logic [5:0] step_up(input logic [5:0] v, input logic [5:0] max_v);
        return (v >= max_v) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] step_dn(input logic [5:0] v, input logic [5:0] max_v);
        return ((v == 6'd0) || (v > max_v)) ? max_v : v - 6'd1;
    endfunction

    // ------------------------------------------------------------------
    // Edit FSM
    // ------------------------------------------------------------------
    state_t      state_reg;
    state_t      state_next;
    logic [4:0]  hour_reg;
    logic [4:0]  hour_next;
    logic [5:0]  min_reg;
    logic [5:0]  min_next;
    logic [5:0]  sec_reg;
    logic [5:0]  sec_next;
    logic        load_reg;
    logic        load_next;
    logic [29:0] to_cnt_reg;
    logic [29:0] to_cnt_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            hour_reg   <= '0;
            min_reg    <= '0;
            sec_reg    <= '0;
            load_reg   <= 1'b0;
            to_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            hour_reg   <= hour_next;
            min_reg    <= min_next;
            sec_reg    <= sec_next;
            load_reg   <= load_next;
            to_cnt_reg <= to_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        hour_next   = hour_reg;
        min_next    = min_reg;
        sec_next    = sec_reg;
        load_next   = 1'b0;
        to_cnt_next = to_cnt_reg;

        if (state_reg == IDLE) begin
            to_cnt_next = '0;
            if (evt[0]) begin
                hour_next  = cur_hour;
                min_next   = cur_min;
                sec_next   = cur_sec;
                state_next = EDIT_H;
            end
        end else begin
            // The if-else chain gives center > up > down > left > right; any
            // lower-priority event in the same cycle is dropped. A press in
            // the timeout cycle wins over the timeout.
            if (evt[0]) begin
                load_next   = 1'b1;
                state_next  = IDLE;
                to_cnt_next = '0;
            end else if (evt[1]) begin
                case (state_reg)
                    EDIT_H:  hour_next = 5'(step_up({1'b0, hour_reg}, 6'd23));
                    EDIT_M:  min_next  = step_up(min_reg, 6'd59);
                    default: sec_next  = step_up(sec_reg, 6'd59);
                endcase
                to_cnt_next = '0;
            end else if (evt[2]) begin
                case (state_reg)
                    EDIT_H:  hour_next = 5'(step_dn({1'b0, hour_reg}, 6'd23));
                    EDIT_M:  min_next  = step_dn(min_reg, 6'd59);
                    default: sec_next  = step_dn(sec_reg, 6'd59);
                endcase
                to_cnt_next = '0;
            end else if (evt[3]) begin
                case (state_reg)
                    EDIT_H:  state_next = EDIT_S;
                    EDIT_M:  state_next = EDIT_H;
                    default: state_next = EDIT_M;
                endcase
                to_cnt_next = '0;
            end else if (evt[4]) begin
                case (state_reg)
                    EDIT_H:  state_next = EDIT_M;
                    EDIT_M:  state_next = EDIT_S;
                    default: state_next = EDIT_H;
                endcase
                to_cnt_next = '0;
            end else if (to_cnt_reg == 30'(TIMEOUT_CYC - 1)) begin
                state_next  = IDLE;
                to_cnt_next = '0;
            end else begin
                to_cnt_next = to_cnt_reg + 30'd1;
            end
        end
    end

    assign set_hour = hour_reg;
    assign set_min  = min_reg;
    assign set_sec  = sec_reg;
    assign load     = load_reg;
    assign editing  = (state_reg != IDLE);
    // State encoding equals the field code.
    assign field    = state_reg;

endmodule
